life_engine: RTL and testbench
==============================

Name: life_engine

Overview:
- Parametrised Conway Game of Life engine: ROWS x COLS cell grid, B3/S23 rule, toroidal or dead-edge boundary.
- Provides seed load, LFSR randomize, single-step and free-run, a generation counter, and stable/extinct halt detection.
- Sits between the control front end (buttons/host) and the display driver.
- Successor to the fixed 8x8 grid core.

Parameters:
- ROWS, 8, grid rows (>=3)
- COLS, 8, grid columns (>=3)
- WRAP, 1, 1 = toroidal neighbours; 0 = off-grid neighbours count as dead
- SEED, all zeros, ROWS*COLS-bit grid value loaded at reset
- LFSR_INIT, 64'hACE1_2024_BEEF_0001, 64-bit LFSR reset value; must be nonzero
- GEN_W, 16, generation counter width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  level; in IDLE enters RUN
- stop  in  1  level; in RUN returns to IDLE
- step  in  1  level; in IDLE advances exactly one generation
- randomize  in  1  level; in IDLE/HALT loads grid from LFSR
- load  in  1  level; in IDLE/HALT loads grid from load_data
- load_data  in  ROWS*COLS  seed pattern
- grid  out  ROWS*COLS  current generation; bit r*COLS+c = row r, col c; bit 0 = row 0, col 0; 1 = alive
- generation  out  GEN_W  generations since last load/randomize/reset
- running  out  1  high while in RUN
- stable  out  1  last evaluated next generation equalled current grid
- extinct  out  1  stable and grid all zero

Behaviour:
- Single clock; all state updates on the rising edge of clk.
- Reset (synchronous, active-high, any state, overrides all inputs):
  - grid=SEED, generation=0, stable=0, extinct=0, running=0, state=IDLE, lfsr=LFSR_INIT.
- LFSR: 64-bit Fibonacci, taps 64,63,61,60. Shifts every non-reset cycle in every state.
  - Randomize fills grid bit i with lfsr[i mod 64], sampled from the pre-edge LFSR value.
- next(grid) is combinational. Neighbour count is 0..8; next cell = (count==3) | (alive & count==2).
  - WRAP=1: row/col indices taken modulo ROWS/COLS.
  - WRAP=0: out-of-range neighbours are 0.
- FSM states: IDLE, RUN, HALT. Per-cycle priority: reset > load > randomize > step > start/stop.
- IDLE:
  - load: grid=load_data, generation=0, flags cleared.
  - randomize: same as load, but grid comes from LFSR.
  - step: if next==grid, set stable (and extinct if grid==0), grid and generation unchanged. Otherwise grid=next, generation+1, flags cleared. Stays in IDLE.
  - start: go to RUN. running goes high the cycle after the start edge.
- RUN, each cycle:
  - stop: go to IDLE. No update on that edge.
  - Else if next==grid: go to HALT, set stable (and extinct if grid==0). grid and generation hold.
  - Else: grid=next, generation+1.
  - load/randomize in RUN are ignored.
- HALT:
  - running=0; grid, generation and flags hold.
  - load or randomize performs the load and goes to IDLE with flags cleared.
  - start/step/stop are ignored.
- Generation counter saturates at 2^GEN_W-1; the grid keeps evolving.
- Only period-1 patterns halt. Oscillators (period >= 2) run indefinitely.
- Simultaneous start and stop in IDLE: start wins. In RUN: stop wins.
- Inputs are level-sensitive; the FSM consumes at most one action per cycle. Edge detection is the caller's job.
- Latency: one generation per clock in RUN. Outputs are registered, so they change on the edge after the deciding input.

Test Plan:
- Reset with SEED=0 -> grid=0, generation=0, running=0, stable=0, extinct=0; hold start during reset -> still IDLE after reset.
- 8x8 WRAP=1, load blinker at row 3 cols 2-4, pulse step -> vertical blinker at col 3 rows 2-4, generation=1; step again -> original horizontal blinker, generation=2, stable=0.
- Load 2x2 block at rows 1-2 cols 1-2, start -> HALT on first RUN edge, stable=1, extinct=0, generation=0, running=0; start ignored afterwards.
- Load single cell, start -> grid=0 and generation=1 after one cycle, then HALT with stable=1, extinct=1.
- 8x8 WRAP=1 glider, run 32 cycles then stop -> grid equals the loaded pattern, generation=32. Same glider with WRAP=0 aimed at a corner -> ends in a 2x2 block, HALT, stable=1.
- Mid-RUN cases:
  - Randomize mid-RUN -> ignored.
  - Reset mid-RUN -> next edge grid=SEED, generation=0, IDLE.
  - Randomize in IDLE after N post-reset cycles -> grid bit i = lfsr[i mod 64] of the reference LFSR model at cycle N.
  - GEN_W=4 run of a non-halting oscillator -> generation holds at 15.

Source files
------------

// File: rtl/life_engine.sv
`default_nettype none
// ============================================================================
//  Module   : life_engine
//  Purpose  : Conway Game of Life engine (B3/S23) on a ROWS x COLS grid with
//             toroidal or dead-edge boundary. Supports seed load, LFSR
//             randomize, single step, free run, a saturating generation
//             counter and stable/extinct halt detection.
//  Revision : 1.0  initial release (successor to the fixed 8x8 core)
// ============================================================================
module life_engine #(
  parameter int                   ROWS      = 8,
  parameter int                   COLS      = 8,
  parameter int                   WRAP      = 1,
  parameter logic [ROWS*COLS-1:0] SEED      = '0,
  parameter logic [63:0]          LFSR_INIT = 64'hACE1_2024_BEEF_0001,
  parameter int                   GEN_W     = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   step,
  input  logic                   randomize,
  input  logic                   load,
  input  logic [ROWS*COLS-1:0]   load_data,
  output logic [ROWS*COLS-1:0]   grid,
  output logic [GEN_W-1:0]       generation,
  output logic                   running,
  output logic                   stable,
  output logic                   extinct
);

  localparam int CELLS = ROWS * COLS;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;

  // Datapath actions chosen by the FSM for the coming edge
  localparam logic [2:0] A_NONE = 3'd0;
  localparam logic [2:0] A_LOAD = 3'd1;
  localparam logic [2:0] A_RAND = 3'd2;
  localparam logic [2:0] A_ADV  = 3'd3;
  localparam logic [2:0] A_MARK = 3'd4;

  localparam logic [GEN_W-1:0] GEN_MAX = '1;

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic [2:0]       action;
  logic [63:0]      lfsr;
  logic [CELLS-1:0] next_grid;
  logic [CELLS-1:0] rand_grid;
  logic             next_same;
  logic             grid_zero;

  // Free-running 64-bit Fibonacci LFSR, taps 64,63,61,60
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr <= LFSR_INIT;
    end else begin
      lfsr <= {lfsr[62:0], lfsr[63] ^ lfsr[62] ^ lfsr[60] ^ lfsr[59]};
    end
  end

  // Randomize pattern: cell i takes LFSR bit i mod 64
  for (genvar i = 0; i < CELLS; i++) begin : g_rand
    assign rand_grid[i] = lfsr[i % 64];
  end

  // Next-generation logic: one neighbour counter per cell
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      logic [8:0] nb;
      logic [3:0] cnt;

      for (genvar k = 0; k < 9; k++) begin : g_nb
        localparam int  DR = (k / 3) - 1;
        localparam int  DC = (k % 3) - 1;
        localparam int  RR = r + DR;
        localparam int  CC = c + DC;
        localparam int  RW = (RR + ROWS) % ROWS;
        localparam int  CW = (CC + COLS) % COLS;
        localparam bit  IN = (RR >= 0) && (RR < ROWS) && (CC >= 0) && (CC < COLS);
        if (k == 4) begin : g_self
          assign nb[k] = 1'b0;
        end else if ((WRAP != 0) || IN) begin : g_live
          assign nb[k] = grid[RW*COLS + CW];
        end else begin : g_edge
          assign nb[k] = 1'b0;
        end
      end

      // Population count of the eight neighbours
      always_comb begin
        cnt = 4'd0;
        for (int k = 0; k < 9; k++) begin
          cnt = cnt + {3'b000, nb[k]};
        end
      end

      assign next_grid[r*COLS + c] = (cnt == 4'd3) | (grid[r*COLS + c] & (cnt == 4'd2));
    end
  end

  assign next_same = (next_grid == grid);
  assign grid_zero = (grid == '0);

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state: load > randomize > step > start/stop
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (!load && !randomize && !step && start) begin
          state_next = S_RUN;
        end
      end
      S_RUN: begin
        if (stop) begin
          state_next = S_IDLE;
        end else if (next_same) begin
          state_next = S_HALT;
        end
      end
      S_HALT: begin
        if (load || randomize) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // FSM outputs: running flag and the datapath action for this edge
  always_comb begin
    action  = A_NONE;
    running = (state == S_RUN);
    case (state)
      S_IDLE: begin
        if (load) begin
          action = A_LOAD;
        end else if (randomize) begin
          action = A_RAND;
        end else if (step) begin
          action = next_same ? A_MARK : A_ADV;
        end
      end
      S_RUN: begin
        if (!stop) begin
          action = next_same ? A_MARK : A_ADV;
        end
      end
      S_HALT: begin
        if (load) begin
          action = A_LOAD;
        end else if (randomize) begin
          action = A_RAND;
        end
      end
      default: action = A_NONE;
    endcase
  end

  // Grid, generation counter and halt flags
  always_ff @(posedge clk) begin
    if (reset) begin
      grid       <= SEED;
      generation <= '0;
      stable     <= 1'b0;
      extinct    <= 1'b0;
    end else begin
      case (action)
        A_LOAD: begin
          grid       <= load_data;
          generation <= '0;
          stable     <= 1'b0;
          extinct    <= 1'b0;
        end
        A_RAND: begin
          grid       <= rand_grid;
          generation <= '0;
          stable     <= 1'b0;
          extinct    <= 1'b0;
        end
        A_ADV: begin
          grid <= next_grid;
          if (generation != GEN_MAX) begin
            generation <= generation + GEN_W'(1);
          end
          stable  <= 1'b0;
          extinct <= 1'b0;
        end
        A_MARK: begin
          stable  <= 1'b1;
          extinct <= grid_zero;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_life_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_life_engine
//  Purpose  : Self-checking bench for life_engine. Three 8x8 instances share
//             one stimulus stream (toroidal/16-bit, dead-edge/16-bit,
//             toroidal/4-bit counter) and are compared every cycle against a
//             grid-level reference model, plus directed pattern checks.
//  Revision : 1.0  initial release
// ============================================================================
module tb_life_engine;

  localparam logic [63:0] LFSR_INIT = 64'hACE1_2024_BEEF_0001;
  localparam logic [63:0] BLINK_H   = (64'd1 << 26) | (64'd1 << 27) | (64'd1 << 28);
  localparam logic [63:0] BLINK_V   = (64'd1 << 19) | (64'd1 << 27) | (64'd1 << 35);
  localparam logic [63:0] BLOCK     = (64'd1 << 9) | (64'd1 << 10) | (64'd1 << 17) | (64'd1 << 18);
  localparam logic [63:0] GLIDER    = (64'd1 << 46) | (64'd1 << 55) | (64'd1 << 61) |
                                      (64'd1 << 62) | (64'd1 << 63);
  localparam logic [63:0] CORNER_BK = (64'd1 << 54) | (64'd1 << 55) | (64'd1 << 62) | (64'd1 << 63);
  localparam int MS_IDLE = 0;
  localparam int MS_RUN  = 1;
  localparam int MS_HALT = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, stop, step, randomize, load;
  logic [63:0] load_data;

  logic [63:0] grid0, grid1, grid2;
  logic [15:0] gen0, gen1;
  logic [3:0]  gen2;
  logic        run0, run1, run2, stb0, stb1, stb2, ext0, ext1, ext2;

  life_engine #(.ROWS(8), .COLS(8), .WRAP(1), .SEED(64'd0), .LFSR_INIT(LFSR_INIT), .GEN_W(16)) dut0 (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .step(step),
    .randomize(randomize), .load(load), .load_data(load_data),
    .grid(grid0), .generation(gen0), .running(run0), .stable(stb0), .extinct(ext0));

  life_engine #(.ROWS(8), .COLS(8), .WRAP(0), .SEED(64'd0), .LFSR_INIT(LFSR_INIT), .GEN_W(16)) dut1 (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .step(step),
    .randomize(randomize), .load(load), .load_data(load_data),
    .grid(grid1), .generation(gen1), .running(run1), .stable(stb1), .extinct(ext1));

  life_engine #(.ROWS(8), .COLS(8), .WRAP(1), .SEED(64'd0), .LFSR_INIT(LFSR_INIT), .GEN_W(4)) dut2 (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .step(step),
    .randomize(randomize), .load(load), .load_data(load_data),
    .grid(grid2), .generation(gen2), .running(run2), .stable(stb2), .extinct(ext2));

  logic [63:0] d_grid [3];
  logic [15:0] d_gen  [3];
  logic        d_run  [3];
  logic        d_stb  [3];
  logic        d_ext  [3];
  assign d_grid[0] = grid0;  assign d_grid[1] = grid1;  assign d_grid[2] = grid2;
  assign d_gen[0]  = gen0;   assign d_gen[1]  = gen1;   assign d_gen[2]  = {12'd0, gen2};
  assign d_run[0]  = run0;   assign d_run[1]  = run1;   assign d_run[2]  = run2;
  assign d_stb[0]  = stb0;   assign d_stb[1]  = stb1;   assign d_stb[2]  = stb2;
  assign d_ext[0]  = ext0;   assign d_ext[1]  = ext1;   assign d_ext[2]  = ext2;

  // Reference model state
  logic [63:0] m_grid [3];
  int          m_gen  [3];
  int          m_state[3];
  bit          m_stb  [3];
  bit          m_ext  [3];
  logic [63:0] m_lfsr;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // B3/S23 over an 8x8 grid, computed cell by cell from row/column indices
  function automatic logic [63:0] life_next(input logic [63:0] g, input bit wrap);
    logic [63:0] res;
    int n, rr, cc;
    res = '0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        n = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if (dr != 0 || dc != 0) begin
              rr = r + dr;
              cc = c + dc;
              if (wrap) begin
                rr = (rr + 8) % 8;
                cc = (cc + 8) % 8;
                n += int'(g[rr*8 + cc]);
              end else if (rr >= 0 && rr < 8 && cc >= 0 && cc < 8) begin
                n += int'(g[rr*8 + cc]);
              end
            end
          end
        end
        res[r*8 + c] = (n == 3) || (g[r*8 + c] && n == 2);
      end
    end
    return res;
  endfunction

  task automatic m_load(input int k, input logic [63:0] v);
    m_grid[k] = v;
    m_gen[k]  = 0;
    m_stb[k]  = 1'b0;
    m_ext[k]  = 1'b0;
  endtask

  task automatic m_mark(input int k);
    m_stb[k] = 1'b1;
    m_ext[k] = (m_grid[k] == 64'd0);
  endtask

  task automatic m_adv(input int k, input logic [63:0] nxt);
    int gmax;
    gmax = (k == 2) ? 15 : 65535;
    m_grid[k] = nxt;
    if (m_gen[k] < gmax) m_gen[k] = m_gen[k] + 1;
    m_stb[k] = 1'b0;
    m_ext[k] = 1'b0;
  endtask

  // Advance one instance's model by one clock using the current inputs
  task automatic model_step(input int k);
    logic [63:0] nxt;
    nxt = life_next(m_grid[k], k != 1);
    if (reset) begin
      m_load(k, 64'd0);
      m_state[k] = MS_IDLE;
    end else if (m_state[k] == MS_IDLE) begin
      if (load) m_load(k, load_data);
      else if (randomize) m_load(k, m_lfsr);
      else if (step) begin
        if (nxt == m_grid[k]) m_mark(k);
        else m_adv(k, nxt);
      end else if (start) m_state[k] = MS_RUN;
    end else if (m_state[k] == MS_RUN) begin
      if (stop) m_state[k] = MS_IDLE;
      else if (nxt == m_grid[k]) begin
        m_mark(k);
        m_state[k] = MS_HALT;
      end else m_adv(k, nxt);
    end else begin
      if (load) begin
        m_load(k, load_data);
        m_state[k] = MS_IDLE;
      end else if (randomize) begin
        m_load(k, m_lfsr);
        m_state[k] = MS_IDLE;
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("i%0d_grid", k), d_grid[k], m_grid[k]);
      check($sformatf("i%0d_gen", k), 64'(d_gen[k]), 64'(m_gen[k]));
      check($sformatf("i%0d_running", k), 64'(d_run[k]), 64'(m_state[k] == MS_RUN));
      check($sformatf("i%0d_stable", k), 64'(d_stb[k]), 64'(m_stb[k]));
      check($sformatf("i%0d_extinct", k), 64'(d_ext[k]), 64'(m_ext[k]));
    end
  endtask

  // One clock: update the model with the inputs seen at the edge, then compare
  task automatic tick();
    for (int k = 0; k < 3; k++) model_step(k);
    if (reset) m_lfsr = LFSR_INIT;
    else m_lfsr = {m_lfsr[62:0], m_lfsr[63] ^ m_lfsr[62] ^ m_lfsr[60] ^ m_lfsr[59]};
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    logic [63:0] exp_rand;
    int n;
    reset = 1'b1; start = 1'b1; stop = 1'b0; step = 1'b0;
    randomize = 1'b0; load = 1'b0; load_data = '0;

    // Reset with start held
    tick();
    tick();
    check("rst_grid", grid0, 64'd0);
    check("rst_gen", 64'(gen0), 64'd0);
    check("rst_running", 64'(run0), 64'd0);
    check("rst_stable", 64'(stb0), 64'd0);
    check("rst_extinct", 64'(ext0), 64'd0);
    reset = 1'b0; start = 1'b0;
    tick();
    check("idle_after_rst", 64'(run0), 64'd0);

    // Blinker stepped twice
    load_data = BLINK_H; load = 1'b1; tick(); load = 1'b0;
    step = 1'b1; tick(); step = 1'b0;
    check("blink_v", grid0, BLINK_V);
    check("blink_v_edge", grid1, BLINK_V);
    check("blink_gen1", 64'(gen0), 64'd1);
    step = 1'b1; tick(); step = 1'b0;
    check("blink_h", grid0, BLINK_H);
    check("blink_gen2", 64'(gen0), 64'd2);
    check("blink_stable0", 64'(stb0), 64'd0);

    // Still life halts on the first run edge
    load_data = BLOCK; load = 1'b1; tick(); load = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    check("block_running", 64'(run0), 64'd1);
    tick();
    check("block_grid", grid0, BLOCK);
    check("block_stable", 64'(stb0), 64'd1);
    check("block_extinct", 64'(ext0), 64'd0);
    check("block_gen", 64'(gen0), 64'd0);
    check("block_halt", 64'(run0), 64'd0);
    start = 1'b1; tick(); start = 1'b0;
    check("halt_ignores_start", 64'(run0), 64'd0);

    // Lone cell dies, then halts as extinct
    load_data = 64'd1 << 36; load = 1'b1; tick(); load = 1'b0;
    check("halt_load_clears", 64'(stb0), 64'd0);
    start = 1'b1; tick(); start = 1'b0;
    tick();
    check("single_dead", grid0, 64'd0);
    check("single_gen1", 64'(gen0), 64'd1);
    tick();
    check("single_stable", 64'(stb0), 64'd1);
    check("single_extinct", 64'(ext0), 64'd1);
    check("single_halt", 64'(run0), 64'd0);

    // Glider: full lap on the torus, block in the dead-edge corner
    load_data = GLIDER; load = 1'b1; tick(); load = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    repeat (32) tick();
    stop = 1'b1; tick(); stop = 1'b0;
    check("glider_lap", grid0, GLIDER);
    check("glider_gen32", 64'(gen0), 64'd32);
    check("glider_stopped", 64'(run0), 64'd0);
    check("glider_gen_sat", 64'(gen2), 64'd15);
    check("corner_block", grid1, CORNER_BK);
    check("corner_stable", 64'(stb1), 64'd1);
    check("corner_gen", 64'(gen1), 64'd3);
    check("corner_halt", 64'(run1), 64'd0);

    // Randomize ignored in RUN, then reset mid-run
    load_data = BLINK_H; load = 1'b1; tick(); load = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    tick();
    randomize = 1'b1; tick(); randomize = 1'b0;
    check("run_rand_grid", grid0, BLINK_H);
    check("run_rand_gen", 64'(gen0), 64'd2);
    check("run_rand_running", 64'(run0), 64'd1);
    reset = 1'b1; tick(); reset = 1'b0;
    check("midrun_rst_grid", grid0, 64'd0);
    check("midrun_rst_gen", 64'(gen0), 64'd0);
    check("midrun_rst_idle", 64'(run0), 64'd0);

    // Randomize in IDLE after a random number of cycles
    n = $urandom_range(3, 40);
    repeat (n) tick();
    exp_rand = m_lfsr;
    randomize = 1'b1; tick(); randomize = 1'b0;
    check("rand_idle_grid", grid0, exp_rand);
    check("rand_idle_grid_edge", grid1, exp_rand);

    // Counter saturation on an oscillator
    load_data = BLINK_H; load = 1'b1; tick(); load = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    repeat (20) tick();
    check("osc_gen20", 64'(gen0), 64'd20);
    check("osc_gen_sat", 64'(gen2), 64'd15);
    check("osc_running", 64'(run2), 64'd1);
    stop = 1'b1; tick(); stop = 1'b0;

    // Randomized control traffic against the model
    repeat (400) begin
      reset     = ($urandom_range(0, 59) == 0);
      load      = ($urandom_range(0, 14) == 0);
      randomize = ($urandom_range(0, 19) == 0);
      step      = ($urandom_range(0, 4) == 0);
      start     = ($urandom_range(0, 5) == 0);
      stop      = ($urandom_range(0, 9) == 0);
      load_data = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
